// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes, protection default and
// the master bridge state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_e;

endpackage

// File: rtl/axi4_lite_master_bridge.sv
// axi4_lite_master_bridge: single-beat CPU load/store to AXI4-Lite master.
// Optional watchdog when AXI_MASTER_TIMEOUT_EN is defined (limit TIMEOUT_CYCLES).
module axi4_lite_master_bridge
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready
);

    localparam int SW = DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]           wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    req_ready_q, req_ready_d;
    logic                    timeout;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) begin
            wd_cnt <= '0;
        end else if (state_q != RESP) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign timeout = (state_q != IDLE) && (state_q != RESP)
                   && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = 1'b0;
        arvalid_d = arvalid_q;
        rready_d  = 1'b0;
        rsp_err_d = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    if (req_we) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                // AW and W retire independently; leave once both are done
                if (awvalid_q && m_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_wready) wvalid_d = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                bready_d = 1'b1;
                if (m_bvalid) begin
                    bready_d  = 1'b0;
                    rsp_err_d = (m_bresp != RESP_OKAY);
                    rdata_d   = '0;
                    state_d   = RESP;
                end
            end
            RD_ADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                rready_d = 1'b1;
                if (m_rvalid) begin
                    rready_d  = 1'b0;
                    rdata_d   = m_rdata;
                    rsp_err_d = (m_rresp != RESP_OKAY);
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog abandons the bus regardless of handshake state
        if (timeout) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            rsp_err_d = 1'b1;
            rdata_d   = '0;
            state_d   = RESP;
        end

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;
    assign m_awaddr  = addr_q;
    assign m_awprot  = PROT_DEFAULT;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_araddr  = addr_q;
    assign m_arprot  = PROT_DEFAULT;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Directed testbench for axi4_lite_master_bridge.
// Timeout scenario runs only when AXI_MASTER_TIMEOUT_EN is defined.
module tb_axi4_lite_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi4_lite_master_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .m_awaddr (m_awaddr),
        .m_awprot (m_awprot),
        .m_awvalid(m_awvalid),
        .m_awready(m_awready),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_wvalid (m_wvalid),
        .m_wready (m_wready),
        .m_bresp  (m_bresp),
        .m_bvalid (m_bvalid),
        .m_bready (m_bready),
        .m_araddr (m_araddr),
        .m_arprot (m_arprot),
        .m_arvalid(m_arvalid),
        .m_arready(m_arready),
        .m_rdata  (m_rdata),
        .m_rresp  (m_rresp),
        .m_rvalid (m_rvalid),
        .m_rready (m_rready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slave_idle();
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
    endtask

    // Present a request and step through the accepting edge.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input logic hold);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        for (int i = 0; i < 10 && !req_ready; i++) step();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL issue_ready: req_ready=%b want 1", req_ready);
        end
        step();
        if (!hold) req_valid = 1'b0;
    endtask

    // Zero/fixed-wait slave; c counts cycles after the accept edge.
    task automatic run_txn(input int aw_dly, input int w_dly, input int ar_dly,
                           output int lat, output int aw_hs, output int w_hs,
                           output int aw_drop, output int w_drop,
                           output int rdy_seen);
        int aw_seen = 0;
        int w_seen = 0;
        int ar_seen = 0;
        int ar_hs = 0;
        int b_hs = 0;
        int r_hs = 0;
        lat = 0; aw_hs = 0; w_hs = 0;
        aw_drop = 0; w_drop = 0; rdy_seen = 0;
        for (int c = 1; c <= 40; c++) begin
            if (rsp_valid) begin
                lat = c;
                break;
            end
            if (!m_awvalid && aw_drop == 0) aw_drop = c;
            if (!m_wvalid && w_drop == 0) w_drop = c;
            m_bvalid  = (aw_hs > 0) && (w_hs > 0) && (b_hs == 0);
            m_rvalid  = (ar_hs > 0) && (r_hs == 0);
            m_awready = m_awvalid && (aw_seen >= aw_dly);
            m_wready  = m_wvalid && (w_seen >= w_dly);
            m_arready = m_arvalid && (ar_seen >= ar_dly);
            if (m_awvalid) aw_seen++;
            if (m_wvalid) w_seen++;
            if (m_arvalid) ar_seen++;
            if (m_awvalid && m_awready) aw_hs++;
            if (m_wvalid && m_wready) w_hs++;
            if (m_arvalid && m_arready) ar_hs++;
            if (m_bvalid && m_bready) b_hs++;
            if (m_rvalid && m_rready) r_hs++;
            if (req_ready) rdy_seen++;
            step();
        end
        slave_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_bad++; $display("FAIL rst_req_ready: got %b want 0", req_ready);
        end
        n_cmp++;
        if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 5'b0) begin
            n_bad++;
            $display("FAIL rst_axi_ctl: got %b want 00000",
                     {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
        end
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== 34'h0) begin
            n_bad++;
            $display("FAIL rst_rsp: got %b/%b/%h want 0/0/0",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        n_cmp++;
        if ({m_awaddr, m_wdata, m_wstrb} !== 68'h0) begin
            n_bad++;
            $display("FAIL rst_data: got %h/%h/%h want 0",
                     m_awaddr, m_wdata, m_wstrb);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL post_rst_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_store_delayed_aw();
        int lat, aw_hs, w_hs, aw_drop, w_drop, rdy;
        m_bresp = 2'b00;
        issue(1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1'b0);
        n_cmp++;
        if ({m_awvalid, m_wvalid, m_arvalid} !== 3'b110) begin
            n_bad++;
            $display("FAIL st_valids: got %b want 110",
                     {m_awvalid, m_wvalid, m_arvalid});
        end
        n_cmp++;
        if ({m_awaddr, m_wdata, m_wstrb, m_awprot} !== {32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 3'b000}) begin
            n_bad++;
            $display("FAIL st_payload: got %h/%h/%h/%b want 10000004/deadbeef/f/000",
                     m_awaddr, m_wdata, m_wstrb, m_awprot);
        end
        run_txn(2, 0, 0, lat, aw_hs, w_hs, aw_drop, w_drop, rdy);
        n_cmp++;
        if (aw_hs != 1 || w_hs != 1) begin
            n_bad++; $display("FAIL st_hs_count: aw=%0d w=%0d want 1/1", aw_hs, w_hs);
        end
        n_cmp++;
        if (w_drop != 2 || aw_drop != 4) begin
            n_bad++;
            $display("FAIL st_drop_order: w=%0d aw=%0d want 2/4", w_drop, aw_drop);
        end
        n_cmp++;
        if (lat != 5) begin
            n_bad++; $display("FAIL st_latency: got %0d want 5", lat);
        end
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            n_bad++;
            $display("FAIL st_rsp: got %b/%b/%h want 1/0/0", rsp_valid, rsp_err, rsp_rdata);
        end
        step();
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL st_rsp_pulse: got v=%b rdy=%b want 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_store_decerr();
        int lat, aw_hs, w_hs, aw_drop, w_drop, rdy;
        m_bresp = 2'b11;
        issue(1'b1, 32'h1000_0100, 32'h0000_00FF, 4'h1, 1'b0);
        run_txn(0, 0, 0, lat, aw_hs, w_hs, aw_drop, w_drop, rdy);
        n_cmp++;
        if (lat != 3) begin
            n_bad++; $display("FAIL st0_latency: got %0d want 3", lat);
        end
        n_cmp++;
        if ({rsp_valid, rsp_err} !== 2'b11) begin
            n_bad++; $display("FAIL st_decerr: got v=%b err=%b want 1/1", rsp_valid, rsp_err);
        end
        m_bresp = 2'b00;
        step();
    endtask

    task automatic test_load();
        int lat, aw_hs, w_hs, aw_drop, w_drop, rdy;
        m_rdata = 32'h1234_5678;
        m_rresp = 2'b00;
        issue(1'b0, 32'h3000_0010, 32'h0, 4'h0, 1'b0);
        n_cmp++;
        if ({m_arvalid, m_awvalid, m_araddr, m_arprot} !== {2'b10, 32'h3000_0010, 3'b000}) begin
            n_bad++;
            $display("FAIL ld_addr: got ar=%b aw=%b %h %b want 1 0 30000010 000",
                     m_arvalid, m_awvalid, m_araddr, m_arprot);
        end
        run_txn(0, 0, 1, lat, aw_hs, w_hs, aw_drop, w_drop, rdy);
        n_cmp++;
        if (lat != 4) begin
            n_bad++; $display("FAIL ld_latency: got %0d want 4", lat);
        end
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h1234_5678}) begin
            n_bad++;
            $display("FAIL ld_rsp: got %b/%b/%h want 1/0/12345678",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        step();
    endtask

    task automatic test_load_slverr();
        int lat, aw_hs, w_hs, aw_drop, w_drop, rdy;
        m_rdata = 32'h0BAD_0BAD;
        m_rresp = 2'b10;
        issue(1'b0, 32'h3000_0020, 32'h0, 4'h0, 1'b0);
        run_txn(0, 0, 0, lat, aw_hs, w_hs, aw_drop, w_drop, rdy);
        n_cmp++;
        if ({rsp_valid, rsp_err} !== 2'b11 || lat != 3) begin
            n_bad++;
            $display("FAIL ld_slverr: got v=%b err=%b lat=%0d want 1/1/3",
                     rsp_valid, rsp_err, lat);
        end
        m_rresp = 2'b00;
        step();
    endtask

    task automatic test_back_to_back();
        int lat, aw_hs, w_hs, aw_drop, w_drop, rdy;
        m_rdata = 32'hCAFE_F00D;
        m_bresp = 2'b00;
        issue(1'b0, 32'h3000_0040, 32'h0, 4'h0, 1'b1);
        run_txn(0, 0, 0, lat, aw_hs, w_hs, aw_drop, w_drop, rdy);
        n_cmp++;
        if (rdy != 0 || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_ready_busy: ready cycles=%0d now=%b want 0/0", rdy, req_ready);
        end
        n_cmp++;
        if (rsp_rdata !== 32'hCAFE_F00D || lat != 3) begin
            n_bad++;
            $display("FAIL b2b_first: got %h lat=%0d want cafef00d/3", rsp_rdata, lat);
        end
        req_we    = 1'b1;
        req_addr  = 32'h2000_0008;
        req_wdata = 32'hA5A5_5A5A;
        req_wstrb = 4'h3;
        step();
        n_cmp++;
        if ({req_ready, rsp_valid, m_awvalid, m_wvalid, m_arvalid} !== 5'b10000) begin
            n_bad++;
            $display("FAIL b2b_gap: got %b want 10000",
                     {req_ready, rsp_valid, m_awvalid, m_wvalid, m_arvalid});
        end
        step();
        req_valid = 1'b0;
        n_cmp++;
        if ({m_awvalid, m_wvalid, m_awaddr, m_wstrb} !== {2'b11, 32'h2000_0008, 4'h3}) begin
            n_bad++;
            $display("FAIL b2b_second: got %b%b %h %h want 11 20000008 3",
                     m_awvalid, m_wvalid, m_awaddr, m_wstrb);
        end
        run_txn(0, 0, 0, lat, aw_hs, w_hs, aw_drop, w_drop, rdy);
        n_cmp++;
        if (lat != 3 || rsp_err !== 1'b0) begin
            n_bad++; $display("FAIL b2b_second_rsp: lat=%0d err=%b want 3/0", lat, rsp_err);
        end
        step();
    endtask

    task automatic test_reset_mid();
        issue(1'b0, 32'h3000_0080, 32'h0, 4'h0, 1'b0);
        m_arready = 1'b1;
        step();
        m_arready = 1'b0;
        n_cmp++;
        if ({m_arvalid, m_rready} !== 2'b01) begin
            n_bad++; $display("FAIL mid_rd_data: got ar=%b r=%b want 0/1", m_arvalid, m_rready);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({m_arvalid, m_rready, rsp_valid, req_ready} !== 4'b0000) begin
            n_bad++;
            $display("FAIL mid_rst: got %b want 0000",
                     {m_arvalid, m_rready, rsp_valid, req_ready});
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if ({req_ready, m_rready, rsp_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL mid_release: got %b want 100", {req_ready, m_rready, rsp_valid});
        end
    endtask

`ifdef AXI_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int ar_cycles = 0;
        int seen = 0;
        m_rdata = 32'hFFFF_FFFF;
        issue(1'b0, 32'h3000_0100, 32'h0, 4'h0, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            if (rsp_valid) begin
                seen = c;
                break;
            end
            if (m_arvalid) ar_cycles++;
            step();
        end
        n_cmp++;
        if (ar_cycles != 16 || seen != 17) begin
            n_bad++;
            $display("FAIL to_cycles: arvalid=%0d rsp_at=%0d want 16/17", ar_cycles, seen);
        end
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_rdata, m_arvalid} !== {2'b11, 32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL to_rsp: got %b/%b/%h ar=%b want 1/1/0 ar=0",
                     rsp_valid, rsp_err, rsp_rdata, m_arvalid);
        end
        step();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        m_bresp   = 2'b00;
        m_rresp   = 2'b00;
        m_rdata   = '0;
        slave_idle();
        test_reset();
        test_store_delayed_aw();
        test_store_decerr();
        test_load();
        test_load_slverr();
        test_back_to_back();
        test_reset_mid();
`ifdef AXI_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
